// File: rtl/axi_mem2p_pkg.sv
// Shared types and address arithmetic for the dual-port AXI memory.
package axi_mem2p_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } burst_t;

   localparam logic [1:0] OKAY   = 2'd0;
   localparam logic [1:0] SLVERR = 2'd2;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   // Reserved burst type 3 falls through to INCR.
   function automatic logic [63:0] next_addr(
      input logic [63:0] addr,
      input logic [2:0]  size,
      input logic [7:0]  len,
      input logic [1:0]  burst
   );
      logic [63:0] step;
      logic [63:0] inc;
      logic [63:0] mask;
      step = 64'd1 << size;
      inc  = addr + step;
      mask = ((64'(len) + 64'd1) << size) - 64'd1;
      case (burst)
         FIXED:   next_addr = addr;
         WRAP:    next_addr = (addr & ~mask) | (inc & mask);
         default: next_addr = inc;
      endcase
   endfunction

endpackage

// File: rtl/axi_mem2p_rd_fifo.sv
// Two-entry output buffer for R beats; head entry is held while stalled.
module axi_mem2p_rd_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wptr;
   logic         rptr;
   logic         do_pop;

   assign do_pop = pop && (count != 2'd0);
   assign dout   = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wptr   <= 1'b0;
         rptr   <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wptr] <= din;
            wptr      <= ~wptr;
         end
         if (do_pop) begin
            rptr <= ~rptr;
         end
         count <= count + {1'b0, push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/axi_mem2p_rd.sv
// AXI4 AR/R responder on memory port B (1-cycle read latency).
// Optional AXI_MEM2P_RD_DECERR_EN: out-of-range beats return SLVERR.
module axi_mem2p_rd
   import axi_mem2p_pkg::*;
#(
   parameter int G_DATAWIDTH     = 32,
   parameter int G_MEMDEPTH      = 1024,
   parameter int G_IDWIDTH       = 4,
   parameter int G_AXI_ADDRWIDTH = 32
) (
   input  logic                       clkb,
   input  logic                       rst,
   input  logic [G_IDWIDTH-1:0]       s_axi_arid,
   input  logic [G_AXI_ADDRWIDTH-1:0] s_axi_araddr,
   input  logic [7:0]                 s_axi_arlen,
   input  logic [2:0]                 s_axi_arsize,
   input  logic [1:0]                 s_axi_arburst,
   input  logic                       s_axi_arvalid,
   output logic                       s_axi_arready,
   output logic [G_IDWIDTH-1:0]       s_axi_rid,
   output logic [G_DATAWIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                 s_axi_rresp,
   output logic                       s_axi_rlast,
   output logic                       s_axi_rvalid,
   input  logic                       s_axi_rready,
   output logic                       enb,
   output logic [$clog2(G_MEMDEPTH)-1:0] addrb,
   input  logic [G_DATAWIDTH-1:0]     doutb
);

   localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH);
   localparam int G_LSB       = $clog2(G_DATAWIDTH/8);
   localparam int PW          = G_IDWIDTH + G_DATAWIDTH + 3;

   state_t                 state;
   state_t                 state_n;
   logic                   arready_q;
   logic [G_IDWIDTH-1:0]   id_q;
   logic [63:0]            addr_q;
   logic [7:0]             len_q;
   logic [7:0]             beat_q;
   logic [2:0]             size_q;
   logic [1:0]             burst_q;
   logic                   inflight_q;
   logic [G_IDWIDTH-1:0]   tag_id_q;
   logic                   tag_last_q;
   logic                   tag_err_q;
   logic                   issue;
   logic                   err;
   logic                   last;
   logic                   pop;
   logic                   ar_hs;
   logic [1:0]             count;
   logic [G_DATAWIDTH-1:0] rdat;
   logic [PW-1:0]          din;
   logic [PW-1:0]          dout;

   assign ar_hs = s_axi_arvalid && arready_q;
   assign pop   = s_axi_rvalid && s_axi_rready;
   assign last  = (beat_q == len_q);

`ifdef AXI_MEM2P_RD_DECERR_EN
   assign err = (addr_q >= (64'(G_MEMDEPTH) << G_LSB));
`else
   assign err = 1'b0;
`endif

   assign s_axi_arready = arready_q;
   assign enb           = issue && !err;
   assign addrb         = addr_q[G_LSB +: G_ADDRWIDTH];

   always_ff @(posedge clkb) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // A pop this cycle frees a slot, so the read can still issue.
   always_comb begin
      state_n = state;
      issue   = 1'b0;
      case (state)
         IDLE: begin
            if (ar_hs) begin
               state_n = BURST;
            end
         end
         BURST: begin
            if ({1'b0, count} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop}) begin
               issue = 1'b1;
               if (last) begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clkb) begin
      if (rst) begin
         arready_q  <= 1'b0;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         inflight_q <= 1'b0;
         tag_id_q   <= '0;
         tag_last_q <= 1'b0;
         tag_err_q  <= 1'b0;
      end else begin
         arready_q  <= (state_n == IDLE);
         inflight_q <= issue;
         tag_id_q   <= id_q;
         tag_last_q <= last;
         tag_err_q  <= err;
         if (state == IDLE && ar_hs) begin
            id_q    <= s_axi_arid;
            addr_q  <= 64'(s_axi_araddr);
            len_q   <= s_axi_arlen;
            size_q  <= s_axi_arsize;
            burst_q <= s_axi_arburst;
            beat_q  <= 8'd0;
         end else if (issue) begin
            beat_q <= beat_q + 8'd1;
            addr_q <= next_addr(addr_q, size_q, len_q, burst_q);
         end
      end
   end

   assign rdat = tag_err_q ? '0 : doutb;
   assign din  = {tag_id_q, rdat, (tag_err_q ? SLVERR : OKAY), tag_last_q};

   axi_mem2p_rd_fifo #(
      .W(PW)
   ) u_fifo (
      .clk   (clkb),
      .rst   (rst),
      .push  (inflight_q),
      .din   (din),
      .pop   (pop),
      .dout  (dout),
      .count (count)
   );

   assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = dout;
   assign s_axi_rvalid = (count != 2'd0);

endmodule

// File: tb/tb_axi_mem2p_rd.sv
// Self-checking bench for axi_mem2p_rd with a behavioural burst model.
module tb_axi_mem2p_rd;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b1;
   logic        enb;
   logic [9:0]  addrb;
   logic [31:0] doutb = '0;

   axi_mem2p_rd dut (
      .clkb          (clk),
      .rst           (rst),
      .s_axi_arid    (arid),
      .s_axi_araddr  (araddr),
      .s_axi_arlen   (arlen),
      .s_axi_arsize  (arsize),
      .s_axi_arburst (arburst),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rid     (rid),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rlast   (rlast),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .enb           (enb),
      .addrb         (addrb),
      .doutb         (doutb)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   typedef struct {
      int       cyc;
      logic [9:0] addr;
   } rd_t;

   logic [31:0] mem [1024];
   beat_t got[$];
   beat_t exp[$];
   rd_t   rds[$];
   int    arc[$];
   int    cyc = 0;
   int    stall_viol = 0;
   int    errors = 0;
   int    checks = 0;
   int    rr_mode = 0;
   logic  prev_stall = 1'b0;
   logic [38:0] prev_out = '0;

   always @(posedge clk) begin
      if (enb) doutb <= mem[addrb];
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
         0:       rready = 1'b1;
         1:       rready = ~rready;
         default: rready = ($urandom_range(0, 3) != 0);
      endcase
   end

   initial forever begin
      @(negedge clk);
      cyc++;
      if (prev_stall && !rst &&
          (!rvalid || {rid, rdata, rresp, rlast} !== prev_out))
         stall_viol++;
      prev_stall = rvalid && !rready && !rst;
      prev_out   = {rid, rdata, rresp, rlast};
      if (!rst && rvalid && rready)
         got.push_back('{cyc, rid, rdata, rresp, rlast});
      if (!rst && enb)
         rds.push_back('{cyc, addrb});
      if (!rst && arvalid && arready)
         arc.push_back(cyc);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=%0d beats exp=%0d", got.size(), exp.size());
      $fatal(1, "timeout");
   end

   function automatic void model(input logic [3:0] id, input int unsigned addr,
                                 input int unsigned len, input int unsigned size,
                                 input int unsigned burst);
      int unsigned step, wsz, base, a;
      beat_t b;
      step = 1 << size;
      wsz  = (len + 1) * step;
      base = (addr / wsz) * wsz;
      for (int unsigned i = 0; i <= len; i++) begin
         if (burst == 0) a = addr;
         else if (burst == 2) a = base + (addr - base + i * step) % wsz;
         else a = addr + i * step;
         b.cyc  = 0;
         b.id   = id;
         b.last = (i == len);
         b.resp = 2'd0;
         b.data = mem[(a / 4) % 1024];
`ifdef AXI_MEM2P_RD_DECERR_EN
         if (a >= 4096) begin
            b.resp = 2'd2;
            b.data = '0;
         end
`endif
         exp.push_back(b);
      end
   endfunction

   task automatic clear_logs();
      got.delete();
      exp.delete();
      rds.delete();
      arc.delete();
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input bit keep);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      arid = id; araddr = addr; arlen = len;
      arsize = size; arburst = burst; arvalid = 1'b1;
      model(id, addr, len, size, burst);
      do begin
         @(negedge clk);
         n++;
      end while (!arready && n < 200);
      checks++;
      if (!arready) begin
         errors++;
         $display("FAIL ar_accept: arready=%0b after %0d cycles, need 1", arready, n);
      end
      @(posedge clk);
      #1;
      if (!keep) arvalid = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int budget);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({arready, rvalid, rlast, rresp, rid, rdata, enb, addrb} !== '0) begin
         errors++;
         $display("FAIL reset_vals: ar=%0b rv=%0b rl=%0b rr=%0d id=%0d d=%h en=%0b a=%0d, need all 0",
                  arready, rvalid, rlast, rresp, rid, rdata, enb, addrb);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (arready !== 1'b0) begin
         errors++;
         $display("FAIL reset_arready_lo: got %0b need 0", arready);
      end
      @(negedge clk);
      checks++;
      if (arready !== 1'b1) begin
         errors++;
         $display("FAIL reset_arready_hi: got %0b need 1", arready);
      end
   endtask

   task automatic test_single();
      clear_logs();
      rr_mode = 0;
      mem[4] = 32'hDEADBEEF;
      do_ar(4'd3, 32'h10, 8'd0, 3'd2, 2'd1, 1'b0);
      wait_beats(1, 50);
      checks++;
      if (rds.size() !== 1 || arc.size() !== 1) begin
         errors++;
         $display("FAIL single_count: reads=%0d ars=%0d, need 1 1", rds.size(), arc.size());
      end else begin
         checks++;
         if (rds[0].cyc !== arc[0] + 1 || rds[0].addr !== 10'd4) begin
            errors++;
            $display("FAIL single_enb: cyc=%0d addr=%0d, need %0d 4", rds[0].cyc, rds[0].addr, arc[0] + 1);
         end
      end
      checks++;
      if (got.size() !== 1) begin
         errors++;
         $display("FAIL single_beats: got %0d need 1", got.size());
      end else begin
         checks++;
         if (arc.size() > 0 && got[0].cyc !== arc[0] + 3) begin
            errors++;
            $display("FAIL single_latency: rvalid cyc %0d need %0d", got[0].cyc, arc[0] + 3);
         end
         checks++;
         if ({got[0].id, got[0].data, got[0].resp, got[0].last} !== {4'd3, 32'hDEADBEEF, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_beat: id=%0d d=%h r=%0d l=%0b, need 3 deadbeef 0 1",
                     got[0].id, got[0].data, got[0].resp, got[0].last);
         end
      end
   endtask

   task automatic test_incr8();
      clear_logs();
      rr_mode = 0;
      do_ar(4'd6, 32'h0, 8'd7, 3'd2, 2'd1, 1'b0);
      wait_beats(8, 100);
      checks++;
      if (rds.size() !== 8 || got.size() !== 8) begin
         errors++;
         $display("FAIL incr8_count: reads=%0d beats=%0d need 8 8", rds.size(), got.size());
      end
      for (int i = 0; i < rds.size() && i < 8; i++) begin
         checks++;
         if (rds[i].addr !== 10'(i) || rds[i].cyc !== rds[0].cyc + i) begin
            errors++;
            $display("FAIL incr8_addr: idx %0d addr=%0d cyc=%0d need %0d %0d",
                     i, rds[i].addr, rds[i].cyc, i, rds[0].cyc + i);
         end
      end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         checks++;
         if ({got[i].id, got[i].data, got[i].resp, got[i].last} !==
             {exp[i].id, exp[i].data, exp[i].resp, exp[i].last} || got[i].cyc !== got[0].cyc + i) begin
            errors++;
            $display("FAIL incr8_beat: idx %0d got %h/%0b cyc %0d need %h/%0b cyc %0d",
                     i, got[i].data, got[i].last, got[i].cyc, exp[i].data, exp[i].last, got[0].cyc + i);
         end
      end
   endtask

   task automatic test_wrap();
      logic [9:0] want [4];
      want[0] = 10'd6; want[1] = 10'd7; want[2] = 10'd4; want[3] = 10'd5;
      clear_logs();
      rr_mode = 0;
      do_ar(4'd9, 32'h18, 8'd3, 3'd2, 2'd2, 1'b0);
      wait_beats(4, 60);
      checks++;
      if (rds.size() !== 4 || got.size() !== 4) begin
         errors++;
         $display("FAIL wrap_count: reads=%0d beats=%0d need 4 4", rds.size(), got.size());
      end
      for (int i = 0; i < rds.size() && i < 4; i++) begin
         checks++;
         if (rds[i].addr !== want[i]) begin
            errors++;
            $display("FAIL wrap_addr: idx %0d got %0d need %0d", i, rds[i].addr, want[i]);
         end
      end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         checks++;
         if ({got[i].id, got[i].data, got[i].last} !== {exp[i].id, exp[i].data, exp[i].last}) begin
            errors++;
            $display("FAIL wrap_beat: idx %0d got %h need %h", i, got[i].data, exp[i].data);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a;
      clear_logs();
      stall_viol = 0;
      rr_mode = 1;
      a = 32'($urandom_range(0, 1000)) << 2;
      do_ar(4'd12, a, 8'd15, 3'd2, 2'd1, 1'b0);
      wait_beats(16, 200);
      rr_mode = 0;
      checks++;
      if (got.size() !== 16) begin
         errors++;
         $display("FAIL bp_count: got %0d need 16", got.size());
      end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         checks++;
         if ({got[i].id, got[i].data, got[i].resp, got[i].last} !==
             {exp[i].id, exp[i].data, exp[i].resp, exp[i].last}) begin
            errors++;
            $display("FAIL bp_beat: idx %0d got %h/%0b need %h/%0b",
                     i, got[i].data, got[i].last, exp[i].data, exp[i].last);
         end
      end
      checks++;
      if (stall_viol !== 0) begin
         errors++;
         $display("FAIL bp_stable: %0d unstable stall cycles, need 0", stall_viol);
      end
   endtask

   task automatic test_back_to_back();
      clear_logs();
      rr_mode = 0;
      do_ar(4'd1, 32'h40, 8'd3, 3'd2, 2'd1, 1'b1);
      do_ar(4'd2, 32'h80, 8'd0, 3'd2, 2'd1, 1'b0);
      wait_beats(5, 60);
      checks++;
      if (arc.size() !== 2 || rds.size() !== 5) begin
         errors++;
         $display("FAIL b2b_count: ars=%0d reads=%0d need 2 5", arc.size(), rds.size());
      end else begin
         checks++;
         if (arc[1] !== rds[3].cyc + 1) begin
            errors++;
            $display("FAIL b2b_accept: second ar cyc %0d need %0d", arc[1], rds[3].cyc + 1);
         end
      end
      checks++;
      if (got.size() !== 5) begin
         errors++;
         $display("FAIL b2b_beats: got %0d need 5", got.size());
      end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         checks++;
         if ({got[i].id, got[i].data, got[i].last} !== {exp[i].id, exp[i].data, exp[i].last}) begin
            errors++;
            $display("FAIL b2b_beat: idx %0d id=%0d d=%h need id=%0d d=%h",
                     i, got[i].id, got[i].data, exp[i].id, exp[i].data);
         end
      end
   endtask

   task automatic test_reset_mid();
      int k;
      clear_logs();
      rr_mode = 0;
      do_ar(4'd7, 32'h100, 8'd7, 3'd2, 2'd1, 1'b0);
      k = 0;
      while (got.size() < 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      clear_logs();
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0 || enb !== 1'b0 || arready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_flush: rvalid=%0b enb=%0b arready=%0b need 0 0 0", rvalid, enb, arready);
      end
      @(negedge clk);
      checks++;
      if (arready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_arready: got %0b need 1", arready);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (got.size() !== 0 || rds.size() !== 0) begin
         errors++;
         $display("FAIL rstmid_stale: beats=%0d reads=%0d need 0 0", got.size(), rds.size());
      end
      do_ar(4'd5, 32'h200, 8'd1, 3'd2, 2'd1, 1'b0);
      wait_beats(2, 40);
      checks++;
      if (got.size() !== 2) begin
         errors++;
         $display("FAIL rstmid_after: got %0d need 2", got.size());
      end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         checks++;
         if ({got[i].id, got[i].data, got[i].last} !== {exp[i].id, exp[i].data, exp[i].last}) begin
            errors++;
            $display("FAIL rstmid_beat: idx %0d got %h need %h", i, got[i].data, exp[i].data);
         end
      end
   endtask

   task automatic test_random();
      int unsigned sz, bt, ln, ad, total;
      clear_logs();
      rr_mode = 2;
      total = 0;
      for (int n = 0; n < 8; n++) begin
         sz = $urandom_range(0, 2);
         bt = $urandom_range(0, 2);
         if (bt == 2) ln = (2 << $urandom_range(0, 3)) - 1;
         else ln = $urandom_range(0, 15);
         ad = $urandom_range(0, 8191) & ~((1 << sz) - 1);
         total += ln + 1;
         do_ar(4'($urandom_range(0, 15)), ad, 8'(ln), 3'(sz), 2'(bt), n != 7);
      end
      wait_beats(int'(total), 2000);
      rr_mode = 0;
      checks++;
      if (got.size() !== int'(total)) begin
         errors++;
         $display("FAIL rand_count: got %0d need %0d", got.size(), total);
      end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         checks++;
         if ({got[i].id, got[i].data, got[i].resp, got[i].last} !==
             {exp[i].id, exp[i].data, exp[i].resp, exp[i].last}) begin
            errors++;
            $display("FAIL rand_beat: idx %0d got %0d/%h/%0d/%0b need %0d/%h/%0d/%0b", i,
                     got[i].id, got[i].data, got[i].resp, got[i].last,
                     exp[i].id, exp[i].data, exp[i].resp, exp[i].last);
         end
      end
   endtask

`ifdef AXI_MEM2P_RD_DECERR_EN
   task automatic test_decerr();
      clear_logs();
      rr_mode = 0;
      do_ar(4'd4, 32'hFFC, 8'd1, 3'd2, 2'd1, 1'b0);
      wait_beats(2, 40);
      checks++;
      if (rds.size() !== 1 || got.size() !== 2) begin
         errors++;
         $display("FAIL decerr_count: reads=%0d beats=%0d need 1 2", rds.size(), got.size());
      end else begin
         checks++;
         if ({got[0].data, got[0].resp, got[0].last, got[1].data, got[1].resp, got[1].last} !==
             {mem[1023], 2'd0, 1'b0, 32'd0, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL decerr_beats: %h/%0d %h/%0d need %h/0 0/2",
                     got[0].data, got[0].resp, got[1].data, got[1].resp, mem[1023]);
         end
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      test_reset();
      test_single();
      test_incr8();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef AXI_MEM2P_RD_DECERR_EN
      test_decerr();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
